noc_ingress_rr_arbiter: RTL

//  Shares one noc_router_adapter_block slave (ingress) port between NUM_REQ local

---
 rtl/noc_arb_pkg.sv | 33 +++
 rtl/rr_priority_pick.sv | 40 ++++
 rtl/noc_ingress_rr_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/noc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_arb_pkg
// Purpose  : Shared types and helpers for the NoC ingress round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package noc_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int DEST_W_DEFAULT = 8;

    // Ceiling log2, never below 1 so index/counter vectors always have a bit.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Purpose  : Combinational round-robin pick: first request after last_grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import noc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [clog2(NUM_REQ)-1:0] i_last_grant,
    output logic [clog2(NUM_REQ)-1:0] o_pick,
    output logic                      o_any_valid
);

    localparam int IDX_W = clog2(NUM_REQ);

    logic [31:0] w_idx;

    // Scan last_grant+1 .. last_grant+NUM_REQ, wrapping; the previous winner is tried last.
    always_comb begin
        o_pick      = '0;
        o_any_valid = 1'b0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = 32'(i_last_grant) + 32'(k);
            if (w_idx >= 32'(NUM_REQ)) begin
                w_idx = w_idx - 32'(NUM_REQ);
            end
            if (!o_any_valid && i_req[w_idx[IDX_W-1:0]]) begin
                o_any_valid = 1'b1;
                o_pick      = w_idx[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_ingress_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_ingress_rr_arbiter
// Purpose  : Round-robin, packet-locked arbiter feeding one NoC adapter ingress
//            port, tagging each beat with the winner's tdest.
// Revision : 1.0 - initial release
// ============================================================================
module noc_ingress_rr_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int noc_dw    = 32,
    parameter int DEST_W    = DEST_W_DEFAULT,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_tvalid,
    input  logic [NUM_REQ*noc_dw-1:0]  req_tdata,
    input  logic [NUM_REQ-1:0]         req_tlast,
    output logic [NUM_REQ-1:0]         req_tready,
    input  logic [NUM_REQ*DEST_W-1:0]  cfg_dest,
    output logic                       out_tvalid,
    output logic [noc_dw-1:0]          out_tdata,
    output logic [DEST_W-1:0]          out_tdest,
    output logic                       out_tlast,
    input  logic                       out_tready,
    output logic [clog2(NUM_REQ)-1:0]  grant_id,
    output logic                       busy
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BURST - 1);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_grant_id;
    logic [IDX_W-1:0]   r_last_grant;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_out_tvalid;
    logic [noc_dw-1:0]  r_out_tdata;
    logic [DEST_W-1:0]  r_out_tdest;
    logic               r_out_tlast;

    logic [IDX_W-1:0]   w_pick;
    logic               w_any_valid;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [noc_dw-1:0]  w_sel_data;
    logic [DEST_W-1:0]  w_sel_dest;
    logic               w_slot_free;
    logic               w_accept;
    logic               w_release;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req        (req_tvalid),
        .i_last_grant (r_last_grant),
        .o_pick       (w_pick),
        .o_any_valid  (w_any_valid)
    );

    // Only the granted requester's lanes reach the output register.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_dest  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == IDX_W'(i)) begin
                w_sel_valid = req_tvalid[i];
                w_sel_last  = req_tlast[i];
                w_sel_data  = req_tdata[i*noc_dw +: noc_dw];
                w_sel_dest  = cfg_dest[i*DEST_W +: DEST_W];
            end
        end
    end

    assign w_slot_free = !r_out_tvalid || out_tready;
    assign w_accept    = (r_state == ST_GRANT) && w_sel_valid && w_slot_free;
    assign w_release   = w_accept && (w_sel_last || (r_beat_cnt == c_last_beat));

    always_comb begin
        req_tready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((r_state == ST_GRANT) && (r_grant_id == IDX_W'(i))) begin
                req_tready[i] = w_slot_free;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
            r_out_tvalid <= 1'b0;
            r_out_tdata  <= '0;
            r_out_tdest  <= '0;
            r_out_tlast  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_tvalid <= 1'b1;
                r_out_tdata  <= w_sel_data;
                r_out_tdest  <= w_sel_dest;
                r_out_tlast  <= w_sel_last;
            end else if (out_tready) begin
                r_out_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_state    <= ST_GRANT;
                        r_grant_id <= w_pick;
                        r_beat_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= r_grant_id;
                        r_beat_cnt   <= '0;
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_tvalid = r_out_tvalid;
    assign out_tdata  = r_out_tdata;
    assign out_tdest  = r_out_tdest;
    assign out_tlast  = r_out_tlast;
    assign grant_id   = r_grant_id;
    assign busy       = (r_state == ST_GRANT);

endmodule
`default_nettype wire
